// File: rtl/fft_sdf_stage_ctrl.sv
// Control sequencer for one radix-2 SDF stage: counts accepted samples and drives
// the delay-line/butterfly phase, twiddle address, output qualifiers and end-of-frame flush.
module fft_sdf_stage_ctrl #(
  parameter int N_POINTS = 32,
  parameter int LOG2N    = 5,
  parameter int STAGE    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       state,
  output logic [LOG2N-2:0] tw_addr,
  output logic             out_mult,
  output logic             out_valid,
  output logic             out_last
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_BFLY  = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

  localparam int D  = N_POINTS >> (STAGE + 1);
  localparam int PB = LOG2N - 1 - STAGE;
  localparam logic [LOG2N-1:0] J_LAST = LOG2N'(D - 1);

  logic [LOG2N-1:0] cnt_q, cnt_d;
  logic [LOG2N-1:0] fcnt_q, fcnt_d;
  logic             pending_q, pending_d;
  logic             flush_q, flush_d;
  state_e           state_q, state_d;
  logic [LOG2N-2:0] tw_q, tw_d;
  logic             mult_q, mult_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic [LOG2N-1:0] j;
  logic [LOG2N-1:0] fnext;
  logic             accept;

  function automatic logic [LOG2N-2:0] tw_of(input logic [LOG2N-1:0] idx);
    logic [LOG2N-1:0] sh;
    sh = idx << STAGE;
    return sh[LOG2N-2:0];
  endfunction

  assign j      = cnt_q & J_LAST;
  assign fnext  = fcnt_q + LOG2N'(1);
  assign accept = in_valid && !flush_q;

  always_comb begin
    // NOTE: every next-state value gets a default first so no path can infer a latch.
    cnt_d     = cnt_q;
    fcnt_d    = fcnt_q;
    pending_d = pending_q;
    flush_d   = flush_q;
    state_d   = ST_IDLE;
    tw_d      = '0;
    mult_d    = 1'b0;
    valid_d   = 1'b0;
    last_d    = 1'b0;

    if (flush_q) begin
      // fcnt_q is the beat on the outputs now; the one after D-1 drops back to IDLE.
      if (fcnt_q != J_LAST) begin
        fcnt_d  = fnext;
        state_d = ST_FLUSH;
        valid_d = 1'b1;
        mult_d  = 1'b1;
        tw_d    = tw_of(fnext);
        if (fnext == J_LAST) begin
          last_d    = 1'b1;
          pending_d = 1'b0;
        end
      end else begin
        flush_d = 1'b0;
      end
    end else if (accept) begin
      cnt_d = cnt_q + LOG2N'(1);
      if (!cnt_q[PB]) begin
        state_d = ST_LOAD;
        if (pending_q) begin
          valid_d = 1'b1;
          mult_d  = 1'b1;
          tw_d    = tw_of(j);
          if (j == J_LAST) begin
            pending_d = 1'b0;
            // Only the first half-group of a frame drains the previous frame's tail.
            last_d    = (cnt_q == J_LAST);
          end
        end
      end else begin
        state_d = ST_BFLY;
        valid_d = 1'b1;
        if (j == J_LAST) begin
          pending_d = 1'b1;
        end
      end
    end else if (cnt_q == '0 && pending_q) begin
      flush_d = 1'b1;
      fcnt_d  = '0;
      state_d = ST_FLUSH;
      valid_d = 1'b1;
      mult_d  = 1'b1;
      if (J_LAST == '0) begin
        last_d    = 1'b1;
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      fcnt_q    <= '0;
      pending_q <= 1'b0;
      flush_q   <= 1'b0;
      state_q   <= ST_IDLE;
      tw_q      <= '0;
      mult_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the same pre-edge values.
      cnt_q     <= cnt_d;
      fcnt_q    <= fcnt_d;
      pending_q <= pending_d;
      flush_q   <= flush_d;
      state_q   <= state_d;
      tw_q      <= tw_d;
      mult_q    <= mult_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
    end
  end

  assign in_ready  = ~flush_q;
  assign state     = state_q;
  assign tw_addr   = tw_q;
  assign out_mult  = mult_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Randomized self-checking bench: four stage instances (STAGE 0,1,3,4) share one input
// stream and are compared each cycle against a queue-of-differences reference model.
module tb_fft_sdf_stage_ctrl;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [3:0] rdy, mult, vld, lst;
  logic [1:0] st [4];
  logic [3:0] tw [4];

  int n_checks;
  int n_fail;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int S = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4;
    fft_sdf_stage_ctrl #(.N_POINTS(32), .LOG2N(5), .STAGE(S)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (rdy[g]),
      .state    (st[g]),
      .tw_addr  (tw[g]),
      .out_mult (mult[g]),
      .out_valid(vld[g]),
      .out_last (lst[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sample index within the frame, pending differences, flush beats left.
  int         m_k  [4];
  int         m_fl [4];
  int         q    [4][$];
  logic [9:0] exp_o[4];
  int         vcnt [4];
  int         fcyc [4];
  logic       rec_b, rec_c;
  logic [5:0] seq_b[$];
  logic [5:0] seq_c[$];

  function automatic int stage_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [9:0] obs(input int i);
    return {rdy[i], st[i], vld[i], mult[i], lst[i], tw[i]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_k[i]  = 0;
      m_fl[i] = 0;
      q[i].delete();
    end
  endtask

  task automatic model_step(input int i, input logic v);
    int s, d, k, e;
    logic [1:0] es;
    logic ev, em, el;
    logic [3:0] et;
    s = stage_of(i);
    d = 32 >> (s + 1);
    e = 0; es = 2'd0; ev = 1'b0; em = 1'b0; el = 1'b0; et = 4'd0;
    if (m_fl[i] > 1) begin
      e = q[i].pop_front(); es = 2'd3; ev = 1'b1; em = 1'b1;
      m_fl[i]--;
    end else if (m_fl[i] == 1) begin
      m_fl[i] = 0;
    end else if (v) begin
      k = m_k[i];
      if ((k % (2 * d)) < d) begin
        es = 2'd1;
        if (q[i].size() > 0) begin
          e = q[i].pop_front(); ev = 1'b1; em = 1'b1;
        end
      end else begin
        es = 2'd2; ev = 1'b1;
        q[i].push_back(((k % d) << s) | ((k == 31) ? 256 : 0));
      end
      m_k[i] = (k + 1) % 32;
    end else if (m_k[i] == 0 && q[i].size() > 0) begin
      e = q[i].pop_front(); es = 2'd3; ev = 1'b1; em = 1'b1;
      m_fl[i] = d;
    end
    if (em) begin
      et = 4'(e & 15);
      el = (e >= 256);
    end
    exp_o[i] = {(m_fl[i] == 0), es, ev, em, el, et};
  endtask

  task automatic cycle(input logic v);
    @(negedge clk);
    in_valid = v;
    for (int i = 0; i < 4; i++) model_step(i, v);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("out_s%0d", stage_of(i)), 32'(obs(i)), 32'(exp_o[i]));
      if (vld[i]) vcnt[i]++;
      if (st[i] == 2'd3) fcyc[i]++;
    end
    if (vld[1] && rec_b) seq_b.push_back({mult[1], lst[1], tw[1]});
    if (vld[1] && rec_c) seq_c.push_back({mult[1], lst[1], tw[1]});
  endtask

  task automatic zero_counts();
    for (int i = 0; i < 4; i++) begin
      vcnt[i] = 0;
      fcyc[i] = 0;
    end
  endtask

  task automatic check_counts(input string tag, input int beats, input logic flush_expected);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_beats_s%0d", tag, stage_of(i)), 32'(vcnt[i]), 32'(beats));
      check($sformatf("%s_flush_s%0d", tag, stage_of(i)), 32'(fcyc[i]),
            flush_expected ? 32'(32 >> (stage_of(i) + 1)) : 32'd0);
    end
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) check($sformatf("rst_s%0d", stage_of(i)), 32'(obs(i)), 32'h200);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int   issued;
    logic found;
    n_checks = 0;
    n_fail   = 0;
    rec_b    = 1'b0;
    rec_c    = 1'b0;
    in_valid = 1'b0;
    rst      = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    async_reset();

    // One frame then idle: flush of the stored differences.
    zero_counts();
    repeat (32) cycle(1'b1);
    repeat (24) cycle(1'b0);
    check_counts("single", 32, 1'b1);

    // Two back-to-back frames: only the final flush.
    zero_counts();
    rec_b = 1'b1;
    repeat (64) cycle(1'b1);
    repeat (24) cycle(1'b0);
    rec_b = 1'b0;
    check_counts("b2b", 64, 1'b1);

    // Same two frames with random gaps, none on a frame boundary.
    zero_counts();
    rec_c  = 1'b1;
    issued = 0;
    while (issued < 64) begin
      if (issued % 32 != 0 && $urandom_range(0, 2) == 0) begin
        cycle(1'b0);
      end else begin
        cycle(1'b1);
        issued++;
      end
    end
    repeat (24) cycle(1'b0);
    rec_c = 1'b0;
    check_counts("gaps", 64, 1'b1);
    check("gap_len", 32'(seq_c.size()), 32'(seq_b.size()));
    for (int n = 0; n < seq_b.size() && n < seq_c.size(); n++)
      check($sformatf("gap_beat%0d", n), 32'(seq_c[n]), 32'(seq_b[n]));

    // Reset while stage 0 shows flush beat 5.
    repeat (32) cycle(1'b1);
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      cycle(1'b0);
      if (st[0] == 2'd3 && tw[0] == 4'd5) found = 1'b1;
    end
    check("flush_beat5_seen", 32'(found), 32'd1);
    async_reset();
    zero_counts();
    repeat (32) cycle(1'b1);
    repeat (24) cycle(1'b0);
    check_counts("post_rst", 32, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
